hc8_boot_loader: RTL and testbench

Bus-initiator program loader for the HC8 system. It receives a byte stream over a valid/ready handshake and writes each byte into the 64 KB RAM through the same bus the CPU uses: address_bus, data_bus, nRAM_RD and nRAM_WR. While loading, it holds the CPU in reset and owns the bus. When loading completes, it tri-states its bus drivers and releases the CPU, which then fetches the freshly written program.

---
 rtl/hc8_boot_loader.sv | 164 ++++++++++++++++
 tb/tb_hc8_boot_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc8_boot_loader.sv
// hc8_boot_loader
//   Bus-initiator program loader. Accepts a byte stream on a valid/ready
//   handshake and writes each byte into RAM over the shared CPU bus, holding
//   the CPU in reset while it owns the bus. On completion it tri-states the
//   bus, releases the CPU and keeps the mod-256 checksum of the load.
//
// Parameters
//   BASE_ADDR   RAM address of the first byte written
//   LOAD_LEN    bytes per load; 0 skips straight to DONE
//
// Ports
//   clk          system clock, rising edge
//   nReset       asynchronous active-low reset
//   in_data      byte to be written
//   in_valid     in_data valid
//   in_ready     loader accepts a byte (WAIT only)
//   address_bus  RAM address, Z when the bus is released
//   data_bus     write data, driven only in SETUP/STROBE/HOLD
//   nRAM_RD      read strobe, held 1 while owning the bus, Z otherwise
//   nRAM_WR      active-low write strobe, Z when the bus is released
//   cpu_nReset   CPU reset, low whenever the loader owns the bus
//   done         load complete, bus released
//   checksum     mod-256 sum of the bytes written in the current load
//   reload       in DONE, restarts a load

module hc8_boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] LOAD_LEN  = 16'd256
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] address_bus,
  inout  logic [7:0]  data_bus,
  output logic        nRAM_RD,
  output logic        nRAM_WR,
  output logic        cpu_nReset,
  output logic        done,
  output logic [7:0]  checksum,
  input  logic        reload
);

  typedef enum logic [2:0] {
    S_START,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_armed;   // first edge after reset release is spent in START
  logic        r_own;     // loader drives address_bus / nRAM_RD / nRAM_WR
  logic        r_drive;   // loader drives data_bus
  logic        r_nwr;
  logic        r_ready;
  logic        r_done;
  logic        r_cpu_n;
  logic [15:0] r_addr;
  logic [15:0] r_count;
  logic [7:0]  r_byte;
  logic [7:0]  r_sum;
  logic [15:0] w_count_inc;

  assign w_count_inc = r_count + 16'd1;

  // All outputs come straight from registers so that ownership, strobe and
  // handshake change on the same edge as the state they belong to.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_START;
      r_armed <= 1'b0;
      r_own   <= 1'b1;
      r_drive <= 1'b0;
      r_nwr   <= 1'b1;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_cpu_n <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_count <= '0;
      r_byte  <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_START: begin
          if (!r_armed) begin
            r_armed <= 1'b1;
          end else begin
            r_count <= '0;
            r_sum   <= '0;
            r_addr  <= BASE_ADDR;
            if (LOAD_LEN == 16'd0) begin
              r_state <= S_DONE;
              r_own   <= 1'b0;
              r_done  <= 1'b1;
              r_cpu_n <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_ready <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            r_byte  <= in_data;
            r_state <= S_SETUP;
            r_ready <= 1'b0;
            r_drive <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          r_nwr   <= 1'b0;
        end
        S_STROBE: begin
          r_state <= S_HOLD;
          r_nwr   <= 1'b1;
        end
        S_HOLD: begin
          r_sum   <= r_sum + r_byte;
          r_count <= w_count_inc;
          r_addr  <= r_addr + 16'd1;
          r_drive <= 1'b0;
          if (w_count_inc == LOAD_LEN) begin
            r_state <= S_DONE;
            r_own   <= 1'b0;
            r_done  <= 1'b1;
            r_cpu_n <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            r_ready <= 1'b1;
          end
        end
        S_DONE: begin
          if (reload) begin
            // Reclaim the bus at BASE_ADDR right away rather than showing
            // the stale end-of-load address during the START cycle.
            r_state <= S_START;
            r_own   <= 1'b1;
            r_done  <= 1'b0;
            r_cpu_n <= 1'b0;
            r_addr  <= BASE_ADDR;
          end
        end
        default: begin
          r_state <= S_START;
        end
      endcase
    end
  end

  assign in_ready    = r_ready;
  assign cpu_nReset  = r_cpu_n;
  assign done        = r_done;
  assign checksum    = r_sum;
  assign address_bus = r_own   ? r_addr : 'z;
  assign nRAM_RD     = r_own   ? 1'b1   : 1'bz;
  assign nRAM_WR     = r_own   ? r_nwr  : 1'bz;
  assign data_bus    = r_drive ? r_byte : 'z;

endmodule

// File: tb/tb_hc8_boot_loader.sv
`timescale 1ns/1ps
module tb_hc8_boot_loader;

  typedef struct {
    logic        vld;
    logic [7:0]  din;
    logic        rdy;
    logic        wr;
    logic        rd;
    logic        cpun;
    logic        dn;
    logic [15:0] ab;
    logic [7:0]  db;
    logic [7:0]  ck;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] nrst;
  logic [3:0] vld;
  logic [3:0] rld;
  logic [7:0] din [4];

  wire [3:0] rdy;
  wire [3:0] cpun;
  wire [3:0] dn;
  wire [7:0] cks [4];

  // Released bus lines float to a recognisable level: address/data/nRAM_WR
  // read as all ones, nRAM_RD reads 0 (it is always 1 when driven).
  tri1 [15:0] ab0, ab1, ab2, ab3;
  tri1 [7:0]  db0, db1, db2, db3;
  tri1        wr0, wr1, wr2, wr3;
  tri0        rd0, rd1, rd2, rd3;

  wire [15:0] ab [4];
  wire [7:0]  db [4];
  wire [3:0]  wr;
  wire [3:0]  rd;
  assign ab[0] = ab0;
  assign ab[1] = ab1;
  assign ab[2] = ab2;
  assign ab[3] = ab3;
  assign db[0] = db0;
  assign db[1] = db1;
  assign db[2] = db2;
  assign db[3] = db3;
  assign wr = {wr3, wr2, wr1, wr0};
  assign rd = {rd3, rd2, rd1, rd0};

  hc8_boot_loader #(.BASE_ADDR(16'h0010), .LOAD_LEN(16'd4)) u_basic (
    .clk(clk), .nReset(nrst[0]), .in_data(din[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .address_bus(ab0), .data_bus(db0), .nRAM_RD(rd0),
    .nRAM_WR(wr0), .cpu_nReset(cpun[0]), .done(dn[0]), .checksum(cks[0]),
    .reload(rld[0]));

  hc8_boot_loader #(.BASE_ADDR(16'hFFFE), .LOAD_LEN(16'd3)) u_wrap (
    .clk(clk), .nReset(nrst[1]), .in_data(din[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .address_bus(ab1), .data_bus(db1), .nRAM_RD(rd1),
    .nRAM_WR(wr1), .cpu_nReset(cpun[1]), .done(dn[1]), .checksum(cks[1]),
    .reload(rld[1]));

  hc8_boot_loader #(.BASE_ADDR(16'h0000), .LOAD_LEN(16'd0)) u_zero (
    .clk(clk), .nReset(nrst[2]), .in_data(din[2]), .in_valid(vld[2]),
    .in_ready(rdy[2]), .address_bus(ab2), .data_bus(db2), .nRAM_RD(rd2),
    .nRAM_WR(wr2), .cpu_nReset(cpun[2]), .done(dn[2]), .checksum(cks[2]),
    .reload(rld[2]));

  hc8_boot_loader #(.BASE_ADDR(16'h0100), .LOAD_LEN(16'd2)) u_reld (
    .clk(clk), .nReset(nrst[3]), .in_data(din[3]), .in_valid(vld[3]),
    .in_ready(rdy[3]), .address_bus(ab3), .data_bus(db3), .nRAM_RD(rd3),
    .nRAM_WR(wr3), .cpu_nReset(cpun[3]), .done(dn[3]), .checksum(cks[3]),
    .reload(rld[3]));

  // RAM model and strobe-shape monitor, sampled on the falling edge.
  logic [7:0]  ram [4][65536];
  int unsigned wr_cnt [4] = '{default: 0};
  int unsigned viol [4]   = '{default: 0};
  logic [3:0]  p_low = '0;
  logic [3:0]  p_own = '0;
  logic [15:0] p_ab [4];
  logic [7:0]  p_db [4];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rd[k] && !wr[k]) begin
        ram[k][ab[k]] <= db[k];
        wr_cnt[k]     <= wr_cnt[k] + 1;
        if (p_low[k] || !p_own[k] || p_ab[k] != ab[k] || p_db[k] != db[k])
          viol[k] <= viol[k] + 1;
      end else if (p_low[k] && (!rd[k] || p_ab[k] != ab[k] || p_db[k] != db[k])) begin
        viol[k] <= viol[k] + 1;
      end
      p_low[k] <= rd[k] && !wr[k];
      p_own[k] <= rd[k];
      p_ab[k]  <= ab[k];
      p_db[k]  <= db[k];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [36:0] obs(input int k);
    return {rdy[k], wr[k], rd[k], cpun[k], dn[k], ab[k], db[k], cks[k]};
  endfunction

  task automatic send_byte(input int k, input logic [7:0] b);
    bit ok = 1'b0;
    vld[k] = 1'b1;
    din[k] = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (rdy[k]) ok = 1'b1;
      step();
    end
    vld[k] = 1'b0;
    chk($sformatf("accept_%0d_%02h", k, b), ok, 1'b1);
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 200 && !dn[k]; i++) step();
    chk($sformatf("done_reached_%0d", k), dn[k], 1'b1);
  endtask

  vec_t tbl [18];
  logic [7:0]  bp_bytes [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
  int unsigned base;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = '0;
    vld  = '0;
    rld  = '0;
    for (int k = 0; k < 4; k++) din[k] = 8'h00;

    //             vld  din    rdy  wr   rd   cpun dn   ab        db     ck
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 8'hFF, 8'h00};
    tbl[1]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 8'hFF, 8'h00};
    tbl[2]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 8'hA5, 8'h00};
    tbl[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'hA5, 8'h00};
    tbl[4]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 8'hA5, 8'h00};
    tbl[5]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0011, 8'hFF, 8'hA5};
    tbl[6]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0011, 8'h3C, 8'hA5};
    tbl[7]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0011, 8'h3C, 8'hA5};
    tbl[8]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0011, 8'h3C, 8'hA5};
    tbl[9]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0012, 8'hFF, 8'hE1};
    tbl[10] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0012, 8'hFF, 8'hE1};
    tbl[11] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0012, 8'hFF, 8'hE1};
    tbl[12] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0012, 8'hFF, 8'hE1};
    tbl[13] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0013, 8'hFF, 8'hE0};
    tbl[14] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0013, 8'h01, 8'hE0};
    tbl[15] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0013, 8'h01, 8'hE0};
    tbl[16] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0013, 8'h01, 8'hE0};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 8'hFF, 8'hE1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_basic", obs(0), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 8'hFF, 8'h00});
    chk("reset_zero",  obs(2), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 8'hFF, 8'h00});

    // Basic load, one row per edge after reset release.
    @(negedge clk);
    nrst[0] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      vld[0] = tbl[i].vld;
      din[0] = tbl[i].din;
      step();
      chk($sformatf("basic_edge%0d", i + 1), obs(0),
          {tbl[i].rdy, tbl[i].wr, tbl[i].rd, tbl[i].cpun, tbl[i].dn,
           tbl[i].ab, tbl[i].db, tbl[i].ck});
    end
    chk("basic_ram", {ram[0][16'h0010], ram[0][16'h0011], ram[0][16'h0012], ram[0][16'h0013]},
        32'hA53CFF01);
    chk("basic_writes", wr_cnt[0], 4);

    // Backpressure: reload, then 5 idle cycles in WAIT between bytes.
    base = wr_cnt[0];
    rld[0] = 1'b1;
    step();
    rld[0] = 1'b0;
    chk("bp_reload_start", {cpun[0], dn[0], rd[0], ab[0]}, {1'b0, 1'b0, 1'b1, 16'h0010});
    for (int b = 0; b < 4; b++) begin
      send_byte(0, bp_bytes[b]);
      if (b < 3) begin
        repeat (3) step();
        for (int g = 0; g < 5; g++) begin
          chk($sformatf("bp_idle_b%0d_c%0d", b, g), {rdy[0], wr[0], rd[0], wr_cnt[0] - base},
              {1'b1, 1'b1, 1'b1, b + 1});
          step();
        end
      end
    end
    wait_done(0);
    chk("bp_ram", {ram[0][16'h0010], ram[0][16'h0011], ram[0][16'h0012], ram[0][16'h0013]},
        32'h10203040);
    chk("bp_checksum", cks[0], 8'hA0);
    chk("bp_writes", wr_cnt[0] - base, 4);

    // Reset during the STROBE of the second byte.
    base = wr_cnt[0];
    rld[0] = 1'b1;
    step();
    rld[0] = 1'b0;
    send_byte(0, 8'h77);
    repeat (3) step();
    send_byte(0, 8'h88);
    step();
    chk("rst_in_strobe", wr[0], 1'b0);
    #1 nrst[0] = 1'b0;
    #1;
    chk("rst_async", {wr[0], rd[0], cpun[0], dn[0], rdy[0], ab[0], cks[0]},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 8'h00});
    @(negedge clk);
    nrst[0] = 1'b1;
    chk("rst_aborted_writes", wr_cnt[0] - base, 1);
    base = wr_cnt[0];
    send_byte(0, 8'h01);
    send_byte(0, 8'h02);
    send_byte(0, 8'h03);
    send_byte(0, 8'h04);
    wait_done(0);
    chk("rst_ram", {ram[0][16'h0010], ram[0][16'h0011], ram[0][16'h0012], ram[0][16'h0013]},
        32'h01020304);
    chk("rst_checksum", cks[0], 8'h0A);
    chk("rst_writes", wr_cnt[0] - base, 4);

    // Address wrap at the top of memory.
    @(negedge clk);
    nrst[1] = 1'b1;
    send_byte(1, 8'h11);
    send_byte(1, 8'h22);
    send_byte(1, 8'h33);
    wait_done(1);
    chk("wrap_ram", {ram[1][16'hFFFE], ram[1][16'hFFFF], ram[1][16'h0000]}, 24'h112233);
    chk("wrap_checksum", cks[1], 8'h66);
    chk("wrap_writes", wr_cnt[1], 3);
    chk("wrap_released", {cpun[1], rd[1], ab[1], db[1]}, {1'b1, 1'b0, 16'hFFFF, 8'hFF});

    // Zero-length load.
    @(negedge clk);
    nrst[2] = 1'b1;
    step();
    chk("zero_edge1", {dn[2], cpun[2], rd[2], ab[2]}, {1'b0, 1'b0, 1'b1, 16'h0000});
    step();
    chk("zero_edge2", {dn[2], cpun[2], rd[2], rdy[2], ab[2], db[2], cks[2]},
        {1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 8'hFF, 8'h00});
    repeat (3) step();
    chk("zero_no_writes", {dn[2], wr_cnt[2]}, {1'b1, 32'd0});

    // Reload: first load, then one-cycle reload pulse and a second load.
    @(negedge clk);
    nrst[3] = 1'b1;
    send_byte(3, 8'h12);
    send_byte(3, 8'h34);
    wait_done(3);
    chk("reld_first_checksum", cks[3], 8'h46);
    base = wr_cnt[3];
    rld[3] = 1'b1;
    step();
    rld[3] = 1'b0;
    chk("reld_start", {cpun[3], dn[3], rd[3], ab[3]}, {1'b0, 1'b0, 1'b1, 16'h0100});
    step();
    chk("reld_wait", {rdy[3], cks[3]}, {1'b1, 8'h00});
    rld[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reld_ignored_%0d", i), {rdy[3], dn[3], cpun[3]}, {1'b1, 1'b0, 1'b0});
    end
    rld[3] = 1'b0;
    send_byte(3, 8'h5A);
    send_byte(3, 8'h5A);
    wait_done(3);
    chk("reld_ram", {ram[3][16'h0100], ram[3][16'h0101]}, 16'h5A5A);
    chk("reld_checksum", cks[3], 8'hB4);
    chk("reld_writes", wr_cnt[3] - base, 2);
    chk("reld_done", {dn[3], cpun[3], rd[3]}, {1'b1, 1'b1, 1'b0});

    step();
    chk("strobe_shape", viol[0] + viol[1] + viol[2] + viol[3], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
